wdg_wb_arbiter: RTL and testbench
=================================

// Module: wdg_wb_arbiter
// PURPOSE
//  Round-robin Wishbone (pipelined) arbiter sharing the single watchdog register port (WDCSR/WDCNT)
//  among N bus masters (e.g. per-hart service tasks + debug). Sits between masters and wdg_top i_wb_*/o_wb_*.
//  Grants one master per bus cycle (cyc high); the grant is held until that master drops cyc.
// PARAMETERS
//  N_MST       2    number of masters, 2..8
//  ADR_W       2    Wishbone address width (= wdg_top REG_ADDRESS_WIDTH)
//  DAT_W       32   Wishbone data width
//  TO_CYCLES   255  slave-response timeout in clk cycles, 1..65535 (used only with WDG_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1            system clock
//  res_n      in   1            asynchronous active-low reset
//  m_cyc      in   N_MST        per-master cyc
//  m_stb      in   N_MST        per-master stb
//  m_we       in   N_MST        per-master we
//  m_adr      in   N_MST*ADR_W  per-master address, master i at [i*ADR_W +: ADR_W]
//  m_dat_w    in   N_MST*DAT_W  per-master write data
//  m_sel      in   N_MST*4      per-master byte select
//  m_stall    out  N_MST        per-master stall
//  m_ack      out  N_MST        per-master ack
//  m_err      out  N_MST        per-master err
//  m_dat_r    out  DAT_W        read data, broadcast (qualify with own ack)
//  s_cyc/s_stb/s_we  out 1      to slave
//  s_adr out ADR_W; s_dat_w out DAT_W; s_sel out 4
//  s_stall/s_ack/s_err in 1; s_dat_r in DAT_W   from slave
//  gnt        out  N_MST        one-hot registered grant (status/debug)
// BEHAVIOUR
//  - Reset: state=IDLE, gnt=0, last=N_MST-1, timeout cnt=0. All s_* outputs 0; m_stall all 1; m_ack/m_err 0.
//  - Non-granted master i: m_stall[i]=1, m_ack[i]=0, m_err[i]=0 at all times.
//  - IDLE: if any m_cyc, pick first requester searching last+1, last+2, ... (wrap mod N_MST);
//    gnt<=onehot(pick), last<=pick, -> BUSY. Grant visible the cycle after request (1-cycle arbitration latency).
//  - BUSY: s_* = granted master's signals combinationally; m_stall/ack/err[g] = s_stall/ack/err.
//    Slave sees s_cyc only while granted m_cyc high (s_cyc = m_cyc[g] & ~abort).
//  - Release: granted m_cyc low -> gnt<=0, -> IDLE; re-arbitration next cycle (1 dead cycle between owners).
//  - Requests arriving during BUSY wait (stalled); no preemption. Simultaneous requests: round-robin order only.
//  - s_ack/s_err while IDLE are dropped (no master receives them).
//  - Masters may hold cyc with multiple pipelined stb; arbiter tracks no outstanding count (master holds cyc).
//  - Reset mid-transfer: immediate return to reset values; s_cyc falls asynchronously.
// CONFIGURATION
//  WDG_ARB_TIMEOUT_EN defined: counter (clog2(TO_CYCLES+1) bits) clears on grant and on each s_ack/s_err,
//    increments every BUSY cycle otherwise; on reaching TO_CYCLES: m_err[g] pulses 1 cycle, s_cyc/s_stb forced 0,
//    -> ABORT; ABORT holds m_stall[g]=1, ignores slave, exits to IDLE when m_cyc[g] drops.
//  Undefined: no counter, no ABORT state; a hung slave holds the grant indefinitely; m_err only mirrors s_err.
// STRUCTURE
//  wdg_pkg: state encoding localparams (ST_IDLE=2'd0, ST_BUSY=2'd1, ST_ABORT=2'd2), clog2 function.
//  Sub-module wdg_rr_pick: combinational round-robin picker (req[N_MST], last idx -> one-hot pick, valid).
//  Top: state/grant/last registers, s_* muxes, m_* demux, optional timeout counter.
// TESTING
//  1 Reset: res_n=0 mid-cycle -> s_cyc=0, gnt=0, m_stall=2'b11, m_ack=0 same cycle.
//  2 Single read: m0 cyc/stb adr=1 -> gnt=01 next clk, s_adr=1, m_ack[0] with m_dat_r=s_dat_r, m_ack[1]=0.
//  3 Simultaneous m0,m1 cyc from reset (last=1) -> m0 first; m0 drops cyc -> 1 idle clk -> gnt=10; repeat -> m0.
//  4 Contention: m1 cyc while m0 BUSY with 3 pipelined writes -> m1 stalled, slave sees only m0 until m0 cyc low.
//  5 Timeout (EN, TO_CYCLES=4): s_ack never asserted -> m_err[0] pulses on 4th BUSY clk, s_cyc=0, IDLE after m0 drops cyc.
//  6 No-EN build, hung slave 1000 clks -> gnt unchanged, m_err=0; then s_ack -> normal completion.

Source files
------------

// File: rtl/wdg_pkg.sv
// Shared definitions for the watchdog Wishbone arbiter: state encoding and a
// constant-evaluable ceiling log2 helper.
package wdg_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_BUSY  = 2'd1;
    localparam state_t ST_ABORT = 2'd2;

    // Minimum result is 1 so a width derived from it is never zero.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/wdg_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping
// modulo N_MST, as a one-hot vector plus its index.
module wdg_rr_pick #(
    parameter int unsigned N_MST = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N_MST-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_MST-1:0] pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             valid
);

    int unsigned idx;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        valid    = 1'b0;
        idx      = 0;
        for (int unsigned k = 1; k <= N_MST; k++) begin
            idx = (32'(last) + k) % N_MST;
            if (!valid && req[idx]) begin
                valid     = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/wdg_wb_arbiter.sv
// Round-robin pipelined-Wishbone arbiter sharing the watchdog register port among N_MST masters.
// Optional slave-response timeout with abort is enabled by defining WDG_ARB_TIMEOUT_EN.
module wdg_wb_arbiter
    import wdg_pkg::*;
#(
    parameter int unsigned N_MST     = 2,
    parameter int unsigned ADR_W     = 2,
    parameter int unsigned DAT_W     = 32,
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic [N_MST-1:0]         m_cyc,
    input  logic [N_MST-1:0]         m_stb,
    input  logic [N_MST-1:0]         m_we,
    input  logic [N_MST*ADR_W-1:0]   m_adr,
    input  logic [N_MST*DAT_W-1:0]   m_dat_w,
    input  logic [N_MST*4-1:0]       m_sel,
    output logic [N_MST-1:0]         m_stall,
    output logic [N_MST-1:0]         m_ack,
    output logic [N_MST-1:0]         m_err,
    output logic [DAT_W-1:0]         m_dat_r,
    output logic                     s_cyc,
    output logic                     s_stb,
    output logic                     s_we,
    output logic [ADR_W-1:0]         s_adr,
    output logic [DAT_W-1:0]         s_dat_w,
    output logic [3:0]               s_sel,
    input  logic                     s_stall,
    input  logic                     s_ack,
    input  logic                     s_err,
    input  logic [DAT_W-1:0]         s_dat_r,
    output logic [N_MST-1:0]         gnt
);

    localparam int unsigned IDX_W = clog2(N_MST);

    state_t             state_q, state_d;
    logic [N_MST-1:0]   gnt_q, gnt_d;
    // last_q doubles as the granted master's index while BUSY/ABORT.
    logic [IDX_W-1:0]   last_q, last_d;
    logic [N_MST-1:0]   pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               hit;
    int unsigned        gsel;

    assign gsel = 32'(last_q);

    wdg_rr_pick #(
        .N_MST (N_MST),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (m_cyc),
        .last     (last_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .valid    (pick_valid)
    );

`ifdef WDG_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = clog2(TO_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Fires on the TO_CYCLES-th consecutive BUSY cycle without a slave response.
    assign hit = (state_q == ST_BUSY) && m_cyc[last_q] && !s_ack && !s_err &&
                 (cnt_q == CNT_W'(TO_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if ((state_q == ST_BUSY) && !s_ack && !s_err && !hit) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= IDX_W'(N_MST - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_BUSY;
                    gnt_d   = pick;
                    last_d  = pick_idx;
                end
            end
            ST_BUSY: begin
                if (!m_cyc[last_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else if (hit) begin
                    state_d = ST_ABORT;
                end
            end
`ifdef WDG_ARB_TIMEOUT_EN
            ST_ABORT: begin
                if (!m_cyc[last_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        m_stall = '1;
        m_ack   = '0;
        m_err   = '0;
        if (state_q == ST_BUSY) begin
            s_cyc           = m_cyc[last_q] & ~hit;
            s_stb           = m_stb[last_q] & ~hit;
            s_we            = m_we[last_q];
            s_adr           = m_adr[gsel*ADR_W +: ADR_W];
            s_dat_w         = m_dat_w[gsel*DAT_W +: DAT_W];
            s_sel           = m_sel[gsel*4 +: 4];
            m_stall[last_q] = s_stall | hit;
            m_ack[last_q]   = s_ack;
            m_err[last_q]   = s_err | hit;
        end
    end

    assign m_dat_r = s_dat_r;
    assign gnt     = gnt_q;

endmodule

// File: tb/tb_wdg_wb_arbiter.sv
// Directed bench for wdg_wb_arbiter; responses are checked by a scoreboard monitor.
// Covers the timeout path when built with WDG_ARB_TIMEOUT_EN.
module tb_wdg_wb_arbiter;

    localparam int unsigned N_MST     = 2;
    localparam int unsigned ADR_W     = 2;
    localparam int unsigned DAT_W     = 32;
    localparam int unsigned TO_CYCLES = 4;

    logic                   clk = 1'b0;
    logic                   res_n;
    logic [N_MST-1:0]       m_cyc, m_stb, m_we;
    logic [N_MST*ADR_W-1:0] m_adr;
    logic [N_MST*DAT_W-1:0] m_dat_w;
    logic [N_MST*4-1:0]     m_sel;
    logic [N_MST-1:0]       m_stall, m_ack, m_err;
    logic [DAT_W-1:0]       m_dat_r;
    logic                   s_cyc, s_stb, s_we;
    logic [ADR_W-1:0]       s_adr;
    logic [DAT_W-1:0]       s_dat_w;
    logic [3:0]             s_sel;
    logic                   s_stall, s_ack, s_err;
    logic [DAT_W-1:0]       s_dat_r;
    logic [N_MST-1:0]       gnt;

    typedef struct packed {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] dat;
    } resp_t;

    resp_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    wdg_wb_arbiter #(
        .N_MST     (N_MST),
        .ADR_W     (ADR_W),
        .DAT_W     (DAT_W),
        .TO_CYCLES (TO_CYCLES)
    ) dut (
        .clk     (clk),
        .res_n   (res_n),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_adr   (m_adr),
        .m_dat_w (m_dat_w),
        .m_sel   (m_sel),
        .m_stall (m_stall),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_dat_r (m_dat_r),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_adr   (s_adr),
        .s_dat_w (s_dat_w),
        .s_sel   (s_sel),
        .s_stall (s_stall),
        .s_ack   (s_ack),
        .s_err   (s_err),
        .s_dat_r (s_dat_r),
        .gnt     (gnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] a, input logic [1:0] e, input logic [31:0] d);
        exp_q.push_back({a, e, d});
    endtask

    // Scoreboard monitor: every ack/err the masters see must match the next queued response.
    always @(negedge clk) begin : mon
        resp_t r;
        if (res_n && (m_ack != '0 || m_err != '0)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: ack=%b err=%b, none queued", m_ack, m_err);
            end else begin
                r = exp_q.pop_front();
                check("resp_ack", 64'(m_ack), 64'(r.ack));
                check("resp_err", 64'(m_err), 64'(r.err));
                if (r.ack != '0) check("resp_dat", 64'(m_dat_r), 64'(r.dat));
            end
        end
    end

    initial begin
        res_n = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0; m_sel = '1;
        s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;

        // Reset state
        sample();
        check("rst_gnt", 64'(gnt), 64'h0);
        check("rst_stall", 64'(m_stall), 64'h3);
        check("rst_s_cyc", 64'(s_cyc), 64'h0);
        check("rst_ack", 64'(m_ack), 64'h0);
        check("rst_err", 64'(m_err), 64'h0);
        step();
        res_n = 1'b1;

        // Single read by m0
        step();
        m_cyc = 2'b01; m_stb = 2'b01; m_adr[1:0] = 2'd1;
        sample();
        check("rd_idle_gnt", 64'(gnt), 64'h0);
        check("rd_idle_s_cyc", 64'(s_cyc), 64'h0);
        step();
        sample();
        check("rd_gnt", 64'(gnt), 64'h1);
        check("rd_s_cyc", 64'(s_cyc), 64'h1);
        check("rd_s_stb", 64'(s_stb), 64'h1);
        check("rd_s_adr", 64'(s_adr), 64'h1);
        check("rd_stall", 64'(m_stall), 64'h2);
        step();
        m_stb = 2'b00; s_ack = 1'b1; s_dat_r = 32'hCAFE_0001;
        push(2'b01, 2'b00, 32'hCAFE_0001);
        sample();
        step();
        s_ack = 1'b0; m_cyc = 2'b00;
        sample();
        check("rd_rel_s_cyc", 64'(s_cyc), 64'h0);
        step();
        sample();
        check("rd_idle_again", 64'(gnt), 64'h0);

        // Slave response while idle is dropped
        step();
        s_ack = 1'b1; s_err = 1'b1; s_dat_r = 32'hDEAD_BEEF;
        sample();
        check("idle_ack_drop", 64'(m_ack), 64'h0);
        check("idle_err_drop", 64'(m_err), 64'h0);
        step();
        s_ack = 1'b0; s_err = 1'b0;

        // Asynchronous reset in the middle of an m1 transfer
        m_cyc = 2'b10; m_stb = 2'b10; m_adr[3:2] = 2'd1;
        step();
        sample();
        check("mid_gnt", 64'(gnt), 64'h2);
        check("mid_s_cyc", 64'(s_cyc), 64'h1);
        step();
        #1;
        res_n = 1'b0; s_ack = 1'b1;
        #1;
        check("arst_s_cyc", 64'(s_cyc), 64'h0);
        check("arst_gnt", 64'(gnt), 64'h0);
        check("arst_stall", 64'(m_stall), 64'h3);
        check("arst_ack", 64'(m_ack), 64'h0);
        m_cyc = 2'b00; m_stb = 2'b00; s_ack = 1'b0;
        step();
        res_n = 1'b1;

        // Simultaneous requests from reset: m0, then m1, then m0 again
        step();
        m_cyc = 2'b11; m_stb = 2'b11; m_adr = {2'd3, 2'd2};
        sample();
        check("sim_idle", 64'(gnt), 64'h0);
        step();
        sample();
        check("sim_first_m0", 64'(gnt), 64'h1);
        check("sim_adr_m0", 64'(s_adr), 64'h2);
        check("sim_stall_m1", 64'(m_stall), 64'h2);
        step();
        m_stb[0] = 1'b0; s_ack = 1'b1; s_dat_r = 32'h0000_0002;
        push(2'b01, 2'b00, 32'h0000_0002);
        step();
        s_ack = 1'b0; m_cyc[0] = 1'b0;
        sample();
        check("sim_hold_m0", 64'(gnt), 64'h1);
        step();
        sample();
        check("sim_dead_gnt", 64'(gnt), 64'h0);
        check("sim_dead_s_cyc", 64'(s_cyc), 64'h0);
        step();
        sample();
        check("sim_second_m1", 64'(gnt), 64'h2);
        check("sim_adr_m1", 64'(s_adr), 64'h3);
        step();
        m_stb[1] = 1'b0; s_ack = 1'b1; s_dat_r = 32'h0000_0003;
        push(2'b10, 2'b00, 32'h0000_0003);
        step();
        s_ack = 1'b0; m_cyc[1] = 1'b0;
        step();
        m_cyc = 2'b11; m_stb = 2'b11;
        step();
        sample();
        check("sim_third_m0", 64'(gnt), 64'h1);
        m_cyc = 2'b00; m_stb = 2'b00;
        step();
        step();
        sample();
        check("sim_rel", 64'(gnt), 64'h0);

        // Contention: m1 waits behind three pipelined m0 writes
        step();
        m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; m_adr = '0;
        m_dat_w[31:0] = 32'h1111_000A; s_stall = 1'b1; s_dat_r = '0;
        sample();
        check("ct_idle", 64'(gnt), 64'h0);
        step();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_adr[3:2] = 2'd3;
        m_dat_w[63:32] = 32'h0000_F00D;
        sample();
        check("ct_gnt", 64'(gnt), 64'h1);
        check("ct_stall_both", 64'(m_stall), 64'h3);
        check("ct_dat_a", 64'(s_dat_w), 64'h1111_000A);
        check("ct_we", 64'(s_we), 64'h1);
        step();
        s_stall = 1'b0;
        sample();
        check("ct_stall_m1", 64'(m_stall), 64'h2);
        step();
        m_dat_w[31:0] = 32'h1111_000B; m_adr[1:0] = 2'd1;
        sample();
        check("ct_dat_b", 64'(s_dat_w), 64'h1111_000B);
        check("ct_adr_b", 64'(s_adr), 64'h1);
        step();
        m_dat_w[31:0] = 32'h1111_000C; m_adr[1:0] = 2'd2; s_ack = 1'b1;
        push(2'b01, 2'b00, 32'h0);
        sample();
        check("ct_dat_c", 64'(s_dat_w), 64'h1111_000C);
        step();
        m_stb[0] = 1'b0;
        push(2'b01, 2'b00, 32'h0);
        sample();
        check("ct_stb_low", 64'(s_stb), 64'h0);
        check("ct_cyc_held", 64'(s_cyc), 64'h1);
        step();
        push(2'b01, 2'b00, 32'h0);
        sample();
        check("ct_still_m0", 64'(gnt), 64'h1);
        step();
        s_ack = 1'b0; m_cyc[0] = 1'b0;
        sample();
        check("ct_s_cyc_drop", 64'(s_cyc), 64'h0);
        step();
        sample();
        check("ct_dead", 64'(gnt), 64'h0);
        check("ct_dead_stall", 64'(m_stall), 64'h3);
        step();
        sample();
        check("ct_m1_gnt", 64'(gnt), 64'h2);
        check("ct_m1_dat", 64'(s_dat_w), 64'h0000_F00D);
        check("ct_m1_cyc", 64'(s_cyc), 64'h1);
        step();
        m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
        step();

        // Slave error mirrored to m1
        step();
        m_cyc = 2'b10; m_stb = 2'b10;
        step();
        step();
        m_stb = 2'b00; s_err = 1'b1;
        push(2'b00, 2'b10, 32'h0);
        step();
        s_err = 1'b0; m_cyc = 2'b00;
        step();
        step();

`ifdef WDG_ARB_TIMEOUT_EN
        // Timeout: slave never answers
        m_cyc = 2'b01; m_stb = 2'b01; m_adr[1:0] = 2'd1;
        step();
        push(2'b00, 2'b01, 32'h0);
        sample();
        check("to_c1_cyc", 64'(s_cyc), 64'h1);
        step();
        step();
        sample();
        check("to_c3_err", 64'(m_err), 64'h0);
        check("to_c3_cyc", 64'(s_cyc), 64'h1);
        step();
        sample();
        check("to_c4_cyc", 64'(s_cyc), 64'h0);
        check("to_c4_stb", 64'(s_stb), 64'h0);
        check("to_c4_stall", 64'(m_stall), 64'h3);
        step();
        s_ack = 1'b1;
        sample();
        check("to_abort_ack", 64'(m_ack), 64'h0);
        check("to_abort_stall", 64'(m_stall), 64'h3);
        check("to_abort_gnt", 64'(gnt), 64'h1);
        check("to_abort_cyc", 64'(s_cyc), 64'h0);
        step();
        s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
        sample();
        check("to_abort_hold", 64'(gnt), 64'h1);
        step();
        sample();
        check("to_idle", 64'(gnt), 64'h0);
`else
        // Hung slave holds the grant indefinitely
        m_cyc = 2'b01; m_stb = 2'b01; m_adr[1:0] = 2'd2;
        step();
        step();
        m_stb = 2'b00;
        for (int i = 0; i < 1000; i++) step();
        sample();
        check("hang_gnt", 64'(gnt), 64'h1);
        check("hang_err", 64'(m_err), 64'h0);
        check("hang_cyc", 64'(s_cyc), 64'h1);
        step();
        s_ack = 1'b1; s_dat_r = 32'h1234_5678;
        push(2'b01, 2'b00, 32'h1234_5678);
        step();
        s_ack = 1'b0; m_cyc = 2'b00;
        step();
        sample();
        check("hang_rel", 64'(gnt), 64'h0);
`endif

        step();
        step();
        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
